// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the opcode byte at pc and, for operand-bearing
// opcodes, the following operand byte, then pulses done with ir/opr valid.
// Supports loading pc from jmp_addr while idle.
module instr_fetch_unit #(
  parameter int          ADDR_W = 8,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              iram_rd,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [7:0]        iram_data,
  output logic [7:0]        ir,
  output logic [7:0]        opr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    OPFETCH = 3'd3,
    OPLATCH = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_hold_reg;

  // CONST (1x) and JMPNZ (5x) carry a second byte; everything else is single-byte.
  function automatic logic has_operand(input logic [7:0] op);
    return (op[7:4] == 4'h1) || (op[7:4] == 4'h5);
  endfunction

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; requests are only looked at in IDLE, and a jump takes
  // priority over a fetch (the fetch is re-sampled on the following cycle).
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (!jmp_en && fetch_req) state_next = FETCH;
      end
      FETCH:   state_next = LATCH;
      LATCH:   state_next = has_operand(iram_data) ? OPFETCH : DONE;
      OPFETCH: state_next = OPLATCH;
      OPLATCH: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; RAM strobe only in the two read states, done only in DONE.
  always_comb begin
    iram_rd = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
    unique case (state_reg)
      IDLE:            busy    = 1'b0;
      FETCH, OPFETCH:  iram_rd = 1'b1;
      DONE:            done    = 1'b1;
      default: ;
    endcase
  end

  // The address bus shows pc during a read and otherwise keeps the last
  // address that was read.
  assign iram_addr = iram_rd ? pc : addr_hold_reg;

  // Datapath: pc advances (modulo 2^ADDR_W) on each read, ir/opr capture the
  // RAM data in the cycle after the corresponding read; opr is untouched for
  // single-byte instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= ADDR_W'(RST_PC);
      ir            <= 8'h00;
      opr           <= 8'h00;
      addr_hold_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (jmp_en) pc <= jmp_addr;
        end
        FETCH, OPFETCH: begin
          addr_hold_reg <= pc;
          pc            <= pc + 1'b1;
        end
        LATCH:   ir  <= iram_data;
        OPLATCH: opr <= iram_data;
        default: ;
      endcase
    end
  end

endmodule
